ps2_key_encoder: RTL and testbench

Converts the raw PS/2 keyboard serial stream (ps2_clk/ps2_data) into the 11-bit toggle-strobed `ps2_key` event word consumed by the core's keyboard decoders. It synchronises and de-glitches the PS/2 lines, deframes 11-bit device-to-host frames, and folds E0/F0 prefix bytes into flags. It emits one event per completed make or break code. It sits between the physical or user-port PS/2 pins and any `ps2_key` consumer in `clk_sys`.

---
 rtl/ps2_key_encoder.sv | 196 +++++++++++++++++++
 tb/tb_ps2_key_encoder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: PS/2 device-to-host deframer producing the toggle-strobed
// 11-bit ps2_key event word. Build option: define PS2_PARITY_CHECK_EN to
// reject frames with a bad (non-odd) parity bit; otherwise parity is ignored.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a start bit (sampled 0)
// DATA   | shifting 8 data bits, LSB first
// PARITY | latching the parity bit
// STOP   | checking stop bit / parity, then processing the byte
module ps2_key_encoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 12000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_stb,
  output logic        frame_err
);

  localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [7:0]    FILT_TC = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_TC   = TW'(TIMEOUT - 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam logic PAR_IGNORE = 1'b0;
`else
  localparam logic PAR_IGNORE = 1'b1;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_f;
  logic [7:0]    filt_cnt;
  logic          samp;
  logic [TW-1:0] to_cnt;
  logic          to_hit;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic          ext, ext_n;
  logic          brk, brk_n;
  logic          par_good;
  logic          emit, err;

  // Two-flop synchronisers on both PS/2 lines; idle-high reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Clock de-glitch: clk_f follows the synced clock only after it has
  // differed for FILTER_LEN consecutive cycles.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_f    <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == clk_f) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_TC) begin
      clk_f    <= ~clk_f;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 8'd1;
    end
  end

  // Sample point is the cycle in which clk_f is about to fall.
  assign samp = clk_f & ~clk_s2 & (filt_cnt == FILT_TC);

  // Idle-in-frame watchdog; a sample point in the same cycle takes priority.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (samp || state == S_IDLE) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_TC) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit   = (state != S_IDLE) && !samp && (to_cnt == TO_TC);
  assign par_good = (^{shift, par}) | PAR_IGNORE;

  // FSM and deframing registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      ext     <= 1'b0;
      brk     <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      par     <= par_n;
      ext     <= ext_n;
      brk     <= brk_n;
    end
  end

  // Next-state, byte processing and error detection.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    ext_n     = ext;
    brk_n     = brk;
    emit      = 1'b0;
    err       = 1'b0;
    if (to_hit) begin
      state_n = S_IDLE;
      err     = 1'b1;
      ext_n   = 1'b0;
      brk_n   = 1'b0;
    end else if (samp) begin
      case (state)
        S_IDLE: begin
          if (!dat_s2) begin
            state_n   = S_DATA;
            bit_cnt_n = '0;
          end else begin
            err   = 1'b1;
            ext_n = 1'b0;
            brk_n = 1'b0;
          end
        end
        S_DATA: begin
          shift_n = {dat_s2, shift[7:1]};
          if (bit_cnt == 3'd7) state_n = S_PARITY;
          else                 bit_cnt_n = bit_cnt + 3'd1;
        end
        S_PARITY: begin
          par_n   = dat_s2;
          state_n = S_STOP;
        end
        S_STOP: begin
          state_n = S_IDLE;
          if (dat_s2 && par_good) begin
            if (shift == 8'hE0) begin
              ext_n = 1'b1;
            end else if (shift == 8'hF0) begin
              brk_n = 1'b1;
            end else begin
              emit  = 1'b1;
              ext_n = 1'b0;
              brk_n = 1'b0;
            end
          end else begin
            err   = 1'b1;
            ext_n = 1'b0;
            brk_n = 1'b0;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Registered event word and pulses, one cycle after the deciding sample.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_key   <= '0;
      key_stb   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_stb   <= emit;
      frame_err <= err;
      if (emit) ps2_key <= {~ps2_key[10], ~brk, ext, shift};
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Scoreboard bench for ps2_key_encoder: expected events are queued as each
// frame is driven and compared when key_stb or frame_err fires.
`timescale 1ns/1ps
module tb_ps2_key_encoder;

  localparam int CLK_HALF = 42;     // ~12 MHz
  localparam int BIT_Q    = 5000;   // quarter PS/2 bit period (ns)

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        key_stb;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  logic [10:0] mkey = '0;
  logic        mext = 1'b0;
  logic        mbrk = 1'b0;

  ps2_key_encoder #(.FILTER_LEN(8), .TIMEOUT(12000)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .key_stb   (key_stb),
    .frame_err (frame_err)
  );

  always #CLK_HALF clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every strobe or error pulse must match the next queued entry.
  always @(negedge clk_sys) begin
    if (reset_n && (key_stb || frame_err)) begin
      if (exp_q.size() == 0) begin
        chk("spurious", {19'd0, key_stb, frame_err, ps2_key}, 32'd0);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("event", {20'd0, frame_err, ps2_key}, {20'd0, e});
        chk("stb", {31'd0, key_stb}, {31'd0, ~e[11]});
      end
    end
  end

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      #BIT_Q;
      ps2_clk = 1'b0;
      #(2 * BIT_Q);
      ps2_clk = 1'b1;
      #BIT_Q;
    end
    ps2_data = 1'b1;
  endtask

  task automatic model_err();
    exp_q.push_back({1'b1, mkey});
    mext = 1'b0;
    mbrk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic p;
    logic par_ok;
    p = (~^b) ^ bad_par;
    par_ok = !bad_par;
`ifndef PS2_PARITY_CHECK_EN
    par_ok = 1'b1;
`endif
    if (!par_ok) begin
      model_err();
    end else if (b == 8'hE0) begin
      mext = 1'b1;
    end else if (b == 8'hF0) begin
      mbrk = 1'b1;
    end else begin
      mkey = {~mkey[10], ~mbrk, mext, b};
      exp_q.push_back({1'b0, mkey});
      mext = 1'b0;
      mbrk = 1'b0;
    end
    send_bits({1'b1, p, b, 1'b0}, 11);
    repeat (40) @(posedge clk_sys);
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    chk("rst_key", {21'd0, ps2_key}, 32'd0);
    chk("rst_stb", {31'd0, key_stb}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);

    send_byte(8'h1C, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'h1C, 1'b1);

    // Partial frame after an E0 prefix; watchdog must abort and drop ext.
    send_byte(8'hE0, 1'b0);
    model_err();
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
    repeat (18000) @(posedge clk_sys);
    chk("timeout", exp_q.size(), 0);
    send_byte(8'h29, 1'b0);
    chk("key29", {24'd0, ps2_key[7:0]}, 32'h29);
    chk("key29_full", {21'd0, ps2_key}, {21'd0, mkey});

    // Short glitch on ps2_clk must not create a sample (would raise start error).
    @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (40) @(posedge clk_sys);
    chk("glitch", exp_q.size(), 0);

    // Reset mid-frame, then a clean frame.
    send_bits({1'b1, 1'b1, 8'h33, 1'b0}, 4);
    @(negedge clk_sys);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    mkey = '0;
    mext = 1'b0;
    mbrk = 1'b0;
    @(negedge clk_sys);
    chk("midrst_key", {21'd0, ps2_key}, 32'd0);
    send_byte(8'h16, 1'b0);
    chk("key16", {21'd0, ps2_key}, {21'd0, mkey});

    chk("final_q", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
